// File: rtl/video_pkg.sv
// Shared timing defaults, capture-state type and a window helper for the
// pixel scanout slice.
package video_pkg;

  localparam int unsigned DEF_H_ACTIVE     = 16;
  localparam int unsigned DEF_H_TOTAL      = 24;
  localparam int unsigned DEF_H_SYNC_START = 18;
  localparam int unsigned DEF_H_SYNC_LEN   = 2;
  localparam int unsigned DEF_V_ACTIVE     = 16;
  localparam int unsigned DEF_V_TOTAL      = 20;
  localparam int unsigned DEF_V_SYNC_START = 17;
  localparam int unsigned DEF_V_SYNC_LEN   = 1;
  localparam int unsigned DEF_LATENCY      = 2;

  localparam int unsigned PIX_W = 4;
  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  // True when pos lies in [start, start+len).
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned start,
                                     input int unsigned len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Two-bank ping-pong line store: one write port and one asynchronous read
// port, each with its own bank select; both banks clear on reset.
module line_buffer
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_H_ACTIVE,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_q [2][DEPTH];
  logic [PIX_W-1:0] mem_d [2][DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/pixel_scanout.sv
// Raster timing generator with line-fill requests and ping-pong line capture.
// Optional SCANOUT_BORDER_EN: drive borderColor instead of 0 outside the active area.
module pixel_scanout
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter int unsigned LATENCY      = DEF_LATENCY,
  parameter int unsigned CHECK_TIMING = 1
) (
  input  logic             clk,
  input  logic             resetN,
  output logic             lineStarting,
  output logic [IDX_W-1:0] lineIndex,
  input  logic [PIX_W-1:0] pixelIn,
  output logic [PIX_W-1:0] pixelOut,
  output logic             pixelValid,
  output logic             hSyncN,
  output logic             vSyncN,
  input  logic [PIX_W-1:0] borderColor,
  output logic             fillUnderrun
);

  localparam int unsigned HW = (H_TOTAL  > 1) ? $clog2(H_TOTAL)  : 1;
  localparam int unsigned VW = (V_TOTAL  > 1) ? $clog2(V_TOTAL)  : 1;
  localparam int unsigned AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LW = $clog2(LATENCY + 1);

  if ((CHECK_TIMING != 0) && (LATENCY + H_ACTIVE > H_TOTAL)) begin : g_bad_timing
    $error("pixel_scanout: LATENCY + H_ACTIVE exceeds H_TOTAL (unsupported)");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("pixel_scanout: LATENCY must be at least 1");
  end

  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [VW-1:0]    next_line;
  logic             wbank_q, wbank_d;
  logic             line_start_q, line_start_d;
  logic [IDX_W-1:0] line_index_q, line_index_d;
  cap_state_e       state_q, state_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
  logic [AW-1:0]    cap_idx_q, cap_idx_d;
  logic             underrun_q, underrun_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_valid_q, pix_valid_d;
  logic             hsync_n_q, hsync_n_d;
  logic             vsync_n_q, vsync_n_d;
  logic             wr_en;
  logic [PIX_W-1:0] rd_data;
  logic [PIX_W-1:0] border_fill;

`ifdef SCANOUT_BORDER_EN
  assign border_fill = borderColor;
`else
  logic unused_border;
  assign unused_border = ^borderColor;
  assign border_fill   = '0;
`endif

  // Raster counters, fill request and bank toggle.
  always_comb begin
    hcnt_d    = hcnt_q + HW'(1);
    vcnt_d    = vcnt_q;
    next_line = (32'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + VW'(1);
    if (32'(hcnt_q) == H_TOTAL - 1) begin
      hcnt_d = '0;
      vcnt_d = next_line;
    end
    line_start_d = (hcnt_q == '0) && (32'(next_line) < V_ACTIVE);
    line_index_d = line_start_d ? IDX_W'(next_line) : line_index_q;
    wbank_d      = wbank_q ^ line_start_d;
  end

  // Capture FSM; a new request always wins and restarts the countdown.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    cap_idx_d = cap_idx_q;
    wr_en     = 1'b0;
    if (line_start_q) begin
      state_d   = (LATENCY == 1) ? CAPTURE : WAIT;
      lat_cnt_d = LW'(LATENCY - 1);
      cap_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT: begin
          if (lat_cnt_q == LW'(1)) begin
            state_d = CAPTURE;
          end else begin
            lat_cnt_d = lat_cnt_q - LW'(1);
          end
        end
        CAPTURE: begin
          wr_en = 1'b1;
          if (32'(cap_idx_q) == H_ACTIVE - 1) begin
            state_d = IDLE;
          end else begin
            cap_idx_d = cap_idx_q + AW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // state_d is the FSM state during the cycle the new request is visible.
    underrun_d = line_start_d && (state_d != IDLE);
  end

  always_comb begin
    pix_valid_d = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    pix_out_d   = pix_valid_d ? rd_data : border_fill;
    hsync_n_d   = !in_window(32'(hcnt_q), H_SYNC_START, H_SYNC_LEN);
    vsync_n_d   = !in_window(32'(vcnt_q), V_SYNC_START, V_SYNC_LEN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      wbank_q      <= 1'b0;
      line_start_q <= 1'b0;
      line_index_q <= '0;
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      cap_idx_q    <= '0;
      underrun_q   <= 1'b0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      hsync_n_q    <= 1'b1;
      vsync_n_q    <= 1'b1;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      wbank_q      <= wbank_d;
      line_start_q <= line_start_d;
      line_index_q <= line_index_d;
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      cap_idx_q    <= cap_idx_d;
      underrun_q   <= underrun_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      hsync_n_q    <= hsync_n_d;
      vsync_n_q    <= vsync_n_d;
    end
  end

  line_buffer #(
    .DEPTH (H_ACTIVE),
    .AW    (AW)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (resetN),
    .wr_en   (wr_en),
    .wr_bank (wbank_q),
    .wr_addr (cap_idx_q),
    .wr_data (pixelIn),
    .rd_bank (~wbank_q),
    .rd_addr (hcnt_q[AW-1:0]),
    .rd_data (rd_data)
  );

  assign lineStarting = line_start_q;
  assign lineIndex    = line_index_q;
  assign pixelOut     = pix_out_q;
  assign pixelValid   = pix_valid_q;
  assign hSyncN       = hsync_n_q;
  assign vSyncN       = vsync_n_q;
  assign fillUnderrun = underrun_q;

endmodule
